// File: rtl/itch_msg_framer.sv
// itch_msg_framer
//   Length-prefixed ITCH message framer. Parses an ingress byte stream of
//   [LEN_BYTES-byte big-endian length][type][payload...] records and forwards
//   each message body (type byte first) as a framed stream with sop/eop.
//   Records with a zero length or a length above MAX_MSG_LEN are flagged on
//   err_len and skipped without producing output.
//
//   Ports
//     clk, rst        clock; synchronous active-high reset
//     rx_data/valid/ready   ingress byte stream (transfer on valid & ready)
//     out_data/valid/ready  body byte stream, one registered stage
//     out_sop, out_eop      first / last body byte, qualified by out_valid
//     out_type, out_len     type and body length of the current/last message
//     err_len               one-cycle pulse on an illegal length
//     msg_count, err_count  saturating statistics (only with ITCH_FRAMER_STATS_EN)
//
//   Configuration macro: ITCH_FRAMER_STATS_EN adds msg_count/err_count.
//
//   state  | meaning
//   S_LEN  | collecting the length prefix, MSB first
//   S_TYPE | waiting for the type byte (first body byte)
//   S_BODY | forwarding the remaining body bytes
//   S_DROP | discarding the body of an oversize record
module itch_msg_framer #(
    parameter int LEN_BYTES   = 2,
    parameter int MAX_MSG_LEN = 64,
    localparam int LEN_W      = 8 * LEN_BYTES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sop,
    output logic             out_eop,
    output logic [7:0]       out_type,
    output logic [LEN_W-1:0] out_len,
    output logic             err_len
`ifdef ITCH_FRAMER_STATS_EN
    ,
    output logic [31:0]      msg_count,
    output logic [15:0]      err_count
`endif
);

    typedef enum logic [1:0] {
        S_LEN  = 2'd0,
        S_TYPE = 2'd1,
        S_BODY = 2'd2,
        S_DROP = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN      = LEN_W'(MAX_MSG_LEN);
    localparam logic [LEN_W-1:0] ONE          = LEN_W'(1);
    localparam logic [LEN_W-1:0] ZERO         = '0;
    localparam logic [2:0]       LAST_LEN_IDX = 3'(LEN_BYTES - 1);

    state_t           state;
    logic [2:0]       byte_cnt;
    logic [LEN_W-1:0] len_acc;
    logic [LEN_W-1:0] len_next;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] drop_cnt;
    logic             rx_fire;
    logic             out_free;

    // The output register can take a new byte when it is empty or being drained
    // this cycle, which gives full throughput with out_ready held high.
    assign out_free = !out_valid || out_ready;
    assign rx_ready = (state == S_LEN || state == S_DROP) ? 1'b1 : out_free;
    assign rx_fire  = rx_valid && rx_ready;

    // Length accumulator with the incoming byte shifted in at the LSB end.
    generate
        if (LEN_BYTES == 1) begin : g_len_one
            assign len_next = rx_data;
        end else begin : g_len_multi
            assign len_next = {len_acc[LEN_W-9:0], rx_data};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_LEN;
            byte_cnt  <= '0;
            len_acc   <= '0;
            remaining <= '0;
            drop_cnt  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_type  <= '0;
            out_len   <= '0;
            err_len   <= 1'b0;
        end else begin
            err_len <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                S_LEN: begin
                    if (rx_fire) begin
                        len_acc <= len_next;
                        if (byte_cnt == LAST_LEN_IDX) begin
                            byte_cnt <= '0;
                            if (len_next == ZERO) begin
                                err_len <= 1'b1;
                            end else if (len_next > MAX_LEN) begin
                                err_len  <= 1'b1;
                                drop_cnt <= len_next;
                                state    <= S_DROP;
                            end else begin
                                state <= S_TYPE;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end
                end

                S_TYPE: begin
                    if (rx_fire) begin
                        out_valid <= 1'b1;
                        out_data  <= rx_data;
                        out_sop   <= 1'b1;
                        out_type  <= rx_data;
                        out_len   <= len_acc;
                        if (len_acc == ONE) begin
                            out_eop <= 1'b1;
                            state   <= S_LEN;
                        end else begin
                            out_eop   <= 1'b0;
                            remaining <= len_acc - ONE;
                            state     <= S_BODY;
                        end
                    end
                end

                S_BODY: begin
                    if (rx_fire) begin
                        out_valid <= 1'b1;
                        out_data  <= rx_data;
                        out_sop   <= 1'b0;
                        out_eop   <= (remaining == ONE);
                        remaining <= remaining - ONE;
                        if (remaining == ONE) begin
                            state <= S_LEN;
                        end
                    end
                end

                S_DROP: begin
                    if (rx_fire) begin
                        drop_cnt <= drop_cnt - ONE;
                        if (drop_cnt == ONE) begin
                            state <= S_LEN;
                        end
                    end
                end

                default: state <= S_LEN;
            endcase
        end
    end

`ifdef ITCH_FRAMER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            msg_count <= '0;
            err_count <= '0;
        end else begin
            if (out_valid && out_ready && out_eop && (msg_count != '1)) begin
                msg_count <= msg_count + 32'd1;
            end
            if (err_len && (err_count != '1)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_itch_msg_framer.sv
module tb_itch_msg_framer;

    localparam int LB    = 2;
    localparam int MAXL  = 64;
    localparam int LEN_W = 8 * LB;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_sop;
    logic             out_eop;
    logic [7:0]       out_type;
    logic [LEN_W-1:0] out_len;
    logic             err_len;
`ifdef ITCH_FRAMER_STATS_EN
    logic [31:0]      msg_count;
    logic [15:0]      err_count;
`endif

    itch_msg_framer #(.LEN_BYTES(LB), .MAX_MSG_LEN(MAXL)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_type  (out_type),
        .out_len   (out_len),
        .err_len   (err_len)
`ifdef ITCH_FRAMER_STATS_EN
        ,
        .msg_count (msg_count),
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Observed traffic: {sop, eop, data} per output transfer
    logic [9:0] got_q[$];
    logic [7:0] stim[$];
    int  err_seen   = 0;
    int  viol_ready = 0;
    int  viol_stall = 0;
    int  ready_mode = 0;      // 0: always ready, 1: random, 2: pattern 1,0,0,1
    int  drive_cycles = 0;
    int  exp_msgs = 0;
    int  exp_errs = 0;

    // Output monitor, sampled on the falling edge
    initial begin
        bit         prev_stall = 1'b0;
        logic [9:0] prev_item  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (out_valid && out_ready) got_q.push_back({out_sop, out_eop, out_data});
                if (err_len) err_seen++;
                if (!rx_ready && !(out_valid && !out_ready)) viol_ready++;
                if (prev_stall && (!out_valid || {out_sop, out_eop, out_data} != prev_item))
                    viol_stall++;
                prev_stall = out_valid && !out_ready;
                prev_item  = {out_sop, out_eop, out_data};
            end
        end
    end

    // Downstream ready generator
    initial begin
        int ph = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: begin
                    out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
                    ph++;
                end
            endcase
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one byte and hold it until accepted (bounded)
    task automatic send_byte(input logic [7:0] b, output bit to);
        bit acc = 1'b0;
        int n   = 0;
        to       = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = rx_ready;
            cycle();
            n++;
            drive_cycles++;
            if (!acc && n > 300) begin
                to = 1'b1;
                break;
            end
        end
    endtask

    task automatic add_rec(input int len);
        for (int k = LB - 1; k >= 0; k--) stim.push_back(8'((len >> (8 * k)) & 255));
        for (int j = 0; j < len; j++) stim.push_back(8'($urandom_range(0, 255)));
    endtask

    // Reference parse of stim, drive, drain and compare
    task automatic run_stream(input int gap_pct, input string name);
        logic [9:0]       exp_q[$];
        int               exp_err = 0;
        bit               has_msg = 1'b0;
        logic [7:0]       exp_type = '0;
        logic [LEN_W-1:0] exp_len  = '0;
        int               idx = 0;
        int               n   = 0;
        bit               to  = 1'b0;

        while (idx < stim.size()) begin
            int len = 0;
            for (int k = 0; k < LB; k++) begin
                len = len * 256 + int'(stim[idx]);
                idx++;
            end
            if (len == 0) begin
                exp_err++;
            end else if (len > MAXL) begin
                exp_err++;
                idx += len;
            end else begin
                exp_type = stim[idx];
                exp_len  = LEN_W'(len);
                has_msg  = 1'b1;
                for (int j = 0; j < len; j++) begin
                    exp_q.push_back({(j == 0), (j == len - 1), stim[idx]});
                    idx++;
                end
            end
        end
        foreach (exp_q[i]) if (exp_q[i][8]) exp_msgs++;
        exp_errs += exp_err;

        got_q.delete();
        err_seen     = 0;
        viol_ready   = 0;
        viol_stall   = 0;
        drive_cycles = 0;
        foreach (stim[i]) begin
            if ($urandom_range(0, 99) < gap_pct) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom_range(0, 255));
                repeat ($urandom_range(1, 3)) cycle();
            end
            send_byte(stim[i], to);
            if (to) break;
        end
        rx_valid = 1'b0;
        while (got_q.size() < exp_q.size() && n < 1000) begin
            cycle();
            n++;
        end
        repeat (4) cycle();

        tests++;
        if (to || n >= 1000) begin
            fails++;
            $display("FAIL %s timeout: ingress_timeout=%0d drain_cycles=%0d", name, to, n);
        end
        tests++;
        if (got_q.size() !== exp_q.size()) begin
            fails++;
            $display("FAIL %s out_count: got %0d expected %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL %s item[%0d] {sop,eop,data}: got %03h expected %03h",
                         name, i, got_q[i], exp_q[i]);
            end
        end
        tests++;
        if (err_seen !== exp_err) begin
            fails++;
            $display("FAIL %s err_len_pulses: got %0d expected %0d", name, err_seen, exp_err);
        end
        if (has_msg) begin
            tests++;
            if (out_type !== exp_type || out_len !== exp_len) begin
                fails++;
                $display("FAIL %s type_len: got %02h/%0d expected %02h/%0d",
                         name, out_type, out_len, exp_type, exp_len);
            end
        end
        tests++;
        if (viol_ready !== 0 || viol_stall !== 0) begin
            fails++;
            $display("FAIL %s handshake: rx_ready_violations=%0d stall_changes=%0d expected 0/0",
                     name, viol_ready, viol_stall);
        end
`ifdef ITCH_FRAMER_STATS_EN
        tests++;
        if (msg_count !== 32'(exp_msgs) || err_count !== 16'(exp_errs)) begin
            fails++;
            $display("FAIL %s stats: got %0d/%0d expected %0d/%0d",
                     name, msg_count, err_count, exp_msgs, exp_errs);
        end
`endif
    endtask

    task automatic test_reset();
        tests++;
        if (out_valid !== 1'b0 || out_sop !== 1'b0 || out_eop !== 1'b0 || out_data !== 8'h00 ||
            out_type !== 8'h00 || out_len !== '0 || err_len !== 1'b0 || rx_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: valid=%b sop=%b eop=%b data=%02h type=%02h len=%0d err=%b rx_ready=%b expected all 0, rx_ready 1",
                     out_valid, out_sop, out_eop, out_data, out_type, out_len, err_len, rx_ready);
        end
`ifdef ITCH_FRAMER_STATS_EN
        tests++;
        if (msg_count !== 32'd0 || err_count !== 16'd0) begin
            fails++;
            $display("FAIL reset_stats: got %0d/%0d expected 0/0", msg_count, err_count);
        end
`endif
    endtask

    task automatic test_basic();
        bit to;
        ready_mode = 0;
        stim = '{8'h00, 8'h03, 8'h41, 8'hAA, 8'hBB};
        run_stream(0, "t1_basic");
        tests++;
        if (drive_cycles !== 5) begin
            fails++;
            $display("FAIL t1_throughput: got %0d cycles expected 5", drive_cycles);
        end
        // Latency: output register must show the type byte right after its accept edge
        send_byte(8'h00, to);
        send_byte(8'h01, to);
        send_byte(8'h53, to);
        tests++;
        if (to || out_valid !== 1'b1 || out_data !== 8'h53 || out_sop !== 1'b1 || out_eop !== 1'b1) begin
            fails++;
            $display("FAIL t1_latency: valid=%b data=%02h sop=%b eop=%b expected 1/53/1/1",
                     out_valid, out_data, out_sop, out_eop);
        end
        rx_valid = 1'b0;
        exp_msgs++;
        repeat (2) cycle();
    endtask

    task automatic test_back_to_back();
        ready_mode = 0;
        stim = '{8'h00, 8'h01, 8'h53, 8'h00, 8'h02, 8'h44, 8'h01};
        run_stream(0, "t2_back_to_back");
    endtask

    task automatic test_oversize();
        ready_mode = 0;
        stim.delete();
        add_rec(MAXL + 1);
        add_rec(MAXL);
        run_stream(0, "t3_oversize_max");
    endtask

    task automatic test_zero_len();
        ready_mode = 0;
        stim = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h45, 8'h07};
        run_stream(0, "t4_zero_len");
    endtask

    task automatic test_stall();
        ready_mode = 2;
        stim.delete();
        add_rec(5);
        run_stream(0, "t5_stall");
        ready_mode = 0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            stim.delete();
            ready_mode = int'($urandom_range(0, 1));
            for (int r = 0; r < int'($urandom_range(4, 8)); r++) begin
                case ($urandom_range(0, 9))
                    0:       add_rec(0);
                    1:       add_rec(MAXL + int'($urandom_range(1, 8)));
                    2:       add_rec(MAXL);
                    3:       add_rec(1);
                    default: add_rec(int'($urandom_range(2, 20)));
                endcase
            end
            run_stream(20, $sformatf("random_%0d", it));
        end
        ready_mode = 0;
        repeat (2) cycle();
    endtask

    task automatic test_reset_mid();
        bit to;
        bit eop_seen = 1'b0;
        ready_mode = 0;
        got_q.delete();
        send_byte(8'h00, to);
        send_byte(8'h06, to);
        send_byte(8'h41, to);
        send_byte(8'h11, to);
        send_byte(8'h22, to);
        rx_valid = 1'b0;
        rst = 1'b1;
        repeat (2) cycle();
        tests++;
        if (out_valid !== 1'b0 || out_sop !== 1'b0 || out_eop !== 1'b0 ||
            out_type !== 8'h00 || out_len !== '0) begin
            fails++;
            $display("FAIL t6_reset_outputs: valid=%b sop=%b eop=%b type=%02h len=%0d expected all 0",
                     out_valid, out_sop, out_eop, out_type, out_len);
        end
        rst = 1'b0;
        exp_msgs = 0;
        exp_errs = 0;
        foreach (got_q[i]) if (got_q[i][8]) eop_seen = 1'b1;
        tests++;
        if (eop_seen !== 1'b0) begin
            fails++;
            $display("FAIL t6_no_eop: got eop_seen=%b expected 0", eop_seen);
        end
        cycle();
        stim = '{8'h00, 8'h01, 8'h46};
        run_stream(0, "t6_after_reset");
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        out_ready = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_oversize();
        test_zero_len();
        test_stall();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
